// File: rtl/mod_i2s_pkg.sv
// Shared I2S definitions used by both the receive and transmit peripherals.
package mod_i2s_pkg;

  typedef enum logic [1:0] {
    SYNC,
    LEFT,
    RIGHT
  } i2s_rx_state_t;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int SYNC_STAGES        = 2;

endpackage

// File: rtl/mod_i2s_rx_if.sv
// Stereo pair output stage of the I2S receiver: held pair with valid/ready plus status.
interface mod_i2s_rx_if
  import mod_i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] o_left;
  logic [DATA_WIDTH-1:0] o_right;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_overrun;
  logic                  o_locked;

  modport master (
    output o_left,
    output o_right,
    output o_valid,
    output o_overrun,
    output o_locked,
    input  i_ready
  );

  modport slave (
    input  o_left,
    input  o_right,
    input  o_valid,
    input  o_overrun,
    input  o_locked,
    output i_ready
  );

endinterface

// File: rtl/mod_sync_edge.sv
// N-flop synchroniser for an asynchronous input with an optional rising-edge strobe.
module mod_sync_edge
  import mod_i2s_pkg::*;
#(
  parameter int STAGES  = SYNC_STAGES,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      q_d   <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = EDGE_EN ? (q & ~q_d) : 1'b0;

endmodule

// File: rtl/mod_i2s_rx.sv
// Slave-mode I2S receiver: oversamples SCK/WS/SD, deserialises left-then-right
// words and presents each completed stereo pair on a valid/ready output stage.
module mod_i2s_rx
  import mod_i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = 6
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_enable,
  input  logic            i_sck,
  input  logic            i_ws,
  input  logic            i_sd,
  mod_i2s_rx_if.master    rx
);

  localparam logic [CNT_WIDTH-1:0] DW_CNT  = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic sck_s_unused, sck_rise;
  logic ws_s, ws_rise_unused;
  logic sd_s, sd_rise_unused;

  mod_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_sck (
    .clk(i_clk), .rst_n(i_rst_n), .d(i_sck), .q(sck_s_unused), .rise(sck_rise)
  );

  mod_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_ws (
    .clk(i_clk), .rst_n(i_rst_n), .d(i_ws), .q(ws_s), .rise(ws_rise_unused)
  );

  mod_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_sd (
    .clk(i_clk), .rst_n(i_rst_n), .d(i_sd), .q(sd_s), .rise(sd_rise_unused)
  );

  i2s_rx_state_t         state, state_n;
  logic                  ws_prev, ws_prev_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic [CNT_WIDTH-1:0]  bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0] left_word, left_word_n;
  logic                  pair_pend, pair_pend_n;
  logic [DATA_WIDTH-1:0] pair_l, pair_l_n;
  logic [DATA_WIDTH-1:0] pair_r, pair_r_n;

  logic [DATA_WIDTH-1:0] sh_in;
  logic [CNT_WIDTH-1:0]  cnt_in;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_end;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= SYNC;
      ws_prev   <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      left_word <= '0;
      pair_pend <= 1'b0;
      pair_l    <= '0;
      pair_r    <= '0;
    end else begin
      state     <= state_n;
      ws_prev   <= ws_prev_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      left_word <= left_word_n;
      pair_pend <= pair_pend_n;
      pair_l    <= pair_l_n;
      pair_r    <= pair_r_n;
    end
  end

  always_comb begin
    state_n     = state;
    ws_prev_n   = ws_prev;
    shreg_n     = shreg;
    bit_cnt_n   = bit_cnt;
    left_word_n = left_word;
    pair_pend_n = 1'b0;
    pair_l_n    = pair_l;
    pair_r_n    = pair_r;

    // The bit at a word-end edge still belongs to the closing word (one-bit
    // delay), so the shifted/counted view is formed first and finalised from it.
    sh_in    = (bit_cnt < DW_CNT) ? {shreg[DATA_WIDTH-2:0], sd_s} : shreg;
    cnt_in   = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + 1'b1;
    word     = (cnt_in >= DW_CNT) ? sh_in : (sh_in << (DW_CNT - cnt_in));
    word_end = (ws_s != ws_prev);

    if (!i_enable) begin
      state_n   = SYNC;
      ws_prev_n = 1'b0;
      shreg_n   = '0;
      bit_cnt_n = '0;
    end else if (sck_rise) begin
      ws_prev_n = ws_s;
      case (state)
        SYNC: begin
          if (ws_prev && !ws_s) begin
            state_n   = LEFT;
            shreg_n   = '0;
            bit_cnt_n = '0;
          end
        end
        LEFT, RIGHT: begin
          if (word_end) begin
            shreg_n   = '0;
            bit_cnt_n = '0;
            if (state == LEFT) begin
              left_word_n = word;
              state_n     = RIGHT;
            end else begin
              pair_l_n    = left_word;
              pair_r_n    = word;
              pair_pend_n = 1'b1;
              state_n     = LEFT;
            end
          end else begin
            shreg_n   = sh_in;
            bit_cnt_n = cnt_in;
          end
        end
        default: state_n = SYNC;
      endcase
    end
  end

  // A completed pair replaces the held one only if it is empty or being taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx.o_left    <= '0;
      rx.o_right   <= '0;
      rx.o_valid   <= 1'b0;
      rx.o_overrun <= 1'b0;
      rx.o_locked  <= 1'b0;
    end else begin
      rx.o_overrun <= 1'b0;
      if (!i_enable) begin
        rx.o_valid  <= 1'b0;
        rx.o_locked <= 1'b0;
      end else if (pair_pend) begin
        rx.o_locked <= 1'b1;
        if (!rx.o_valid || rx.i_ready) begin
          rx.o_left  <= pair_l;
          rx.o_right <= pair_r;
          rx.o_valid <= 1'b1;
        end else begin
          rx.o_overrun <= 1'b1;
        end
      end else if (rx.o_valid && rx.i_ready) begin
        rx.o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mod_i2s_rx.sv
// Directed bench for mod_i2s_rx: I2S frames driven at SCK = clk/16, pairs checked
// against hand-computed words, latency, backpressure, resync and mid-frame reset.
module tb_mod_i2s_rx;

  logic i_clk = 1'b0;
  logic i_rst_n, i_enable, i_sck, i_ws, i_sd;

  mod_i2s_rx_if #(.DATA_WIDTH(16)) rx ();

  mod_i2s_rx #(.DATA_WIDTH(16), .CNT_WIDTH(6)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
    .i_sck(i_sck), .i_ws(i_ws), .i_sd(i_sd), .rx(rx)
  );

  always #5 i_clk = ~i_clk;

  int unsigned n_cmp = 0, n_err = 0;
  int unsigned cyc = 0, rise_cyc = 0;
  int unsigned n_vrise = 0, n_vhigh = 0, n_ovr = 0, mon_lat = 0;
  logic [15:0] mon_l = '0, mon_r = '0;
  logic mon_lock = 1'b0, mon_lock_prev = 1'b0, valid_prev = 1'b0, lock_prev = 1'b0;
  int unsigned v0, h0, o0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Pair monitor: records the pair, latency and lock state at each o_valid rise.
  always @(negedge i_clk) begin
    valid_prev <= rx.o_valid;
    lock_prev  <= rx.o_locked;
    if (rx.o_valid)   n_vhigh <= n_vhigh + 1;
    if (rx.o_overrun) n_ovr   <= n_ovr + 1;
    if (rx.o_valid && !valid_prev) begin
      n_vrise       <= n_vrise + 1;
      mon_l         <= rx.o_left;
      mon_r         <= rx.o_right;
      mon_lat       <= cyc - rise_cyc;
      mon_lock      <= rx.o_locked;
      mon_lock_prev <= lock_prev;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sck_bit(input logic ws, input logic sd);
    i_sck = 1'b0;
    i_ws  = ws;
    i_sd  = sd;
    repeat (8) @(negedge i_clk);
    i_sck    = 1'b1;
    rise_cyc = cyc;
    repeat (8) @(negedge i_clk);
  endtask

  // WS flips on the LSB of each word (one-bit delay before the next MSB).
  task automatic send_frame(input logic [31:0] l, input int nl, input logic [31:0] r, input int nr);
    for (int i = nl - 1; i >= 0; i--) sck_bit(i == 0, l[i]);
    for (int i = nr - 1; i >= 0; i--) sck_bit(i != 0, r[i]);
    repeat (4) @(negedge i_clk);
  endtask

  task automatic preamble();
    sck_bit(1'b1, 1'b0);
    sck_bit(1'b1, 1'b0);
    sck_bit(1'b0, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] part;
    i_rst_n = 1'b0; i_enable = 1'b0; i_sck = 1'b0; i_ws = 1'b0; i_sd = 1'b0;
    rx.i_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    check_eq("rst_valid",   rx.o_valid,   0);
    check_eq("rst_left",    rx.o_left,    0);
    check_eq("rst_right",   rx.o_right,   0);
    check_eq("rst_overrun", rx.o_overrun, 0);
    check_eq("rst_locked",  rx.o_locked,  0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // nominal 16-bit slots
    i_enable = 1'b1; rx.i_ready = 1'b1;
    preamble();
    v0 = n_vrise; h0 = n_vhigh;
    send_frame(32'hA5A5, 16, 32'h1234, 16);
    check_eq("nom_pairs",     n_vrise - v0, 1);
    check_eq("nom_width",     n_vhigh - h0, 1);
    check_eq("nom_left",      mon_l, 16'hA5A5);
    check_eq("nom_right",     mon_r, 16'h1234);
    check_eq("nom_latency",   mon_lat, 4);
    check_eq("nom_lock",      mon_lock, 1);
    check_eq("nom_lock_prev", mon_lock_prev, 0);
    check_eq("nom_valid_end", rx.o_valid, 0);

    // 24-bit slots truncate
    v0 = n_vrise;
    send_frame(32'hABCDEF, 24, 32'h123456, 24);
    check_eq("wide_pairs", n_vrise - v0, 1);
    check_eq("wide_left",  mon_l, 16'hABCD);
    check_eq("wide_right", mon_r, 16'h1234);

    // 12-bit slots zero-pad at the LSB end
    v0 = n_vrise;
    send_frame(32'hFFF, 12, 32'h801, 12);
    check_eq("short_pairs", n_vrise - v0, 1);
    check_eq("short_left",  mon_l, 16'hFFF0);
    check_eq("short_right", mon_r, 16'h8010);

    // 1-bit left slot
    v0 = n_vrise;
    send_frame(32'h1, 1, 32'h8001, 16);
    check_eq("one_pairs", n_vrise - v0, 1);
    check_eq("one_left",  mon_l, 16'h8000);
    check_eq("one_right", mon_r, 16'h8001);
    check_eq("pre_bp_ovr", n_ovr, 0);

    // backpressure: first pair held, next two dropped
    rx.i_ready = 1'b0;
    v0 = n_vrise; o0 = n_ovr;
    send_frame(32'h1111, 16, 32'h2222, 16);
    send_frame(32'h3333, 16, 32'h4444, 16);
    send_frame(32'h5555, 16, 32'h6666, 16);
    check_eq("bp_pairs",   n_vrise - v0, 1);
    check_eq("bp_overrun", n_ovr - o0, 2);
    check_eq("bp_valid",   rx.o_valid, 1);
    check_eq("bp_left",    rx.o_left, 16'h1111);
    check_eq("bp_right",   rx.o_right, 16'h2222);
    rx.i_ready = 1'b1;
    @(negedge i_clk);
    check_eq("bp_pop_valid", rx.o_valid, 0);
    check_eq("bp_pop_left",  rx.o_left, 16'h1111);

    // disable, then resume mid-right-slot
    i_enable = 1'b0;
    repeat (2) @(negedge i_clk);
    check_eq("dis_locked", rx.o_locked, 0);
    check_eq("dis_valid",  rx.o_valid, 0);
    check_eq("dis_left",   rx.o_left, 16'h1111);
    i_enable = 1'b1;
    v0 = n_vrise;
    repeat (5) sck_bit(1'b1, 1'b1);
    sck_bit(1'b0, 1'b1);
    check_eq("mid_no_pair", n_vrise - v0, 0);
    check_eq("mid_unlocked", rx.o_locked, 0);
    send_frame(32'hCAFE, 16, 32'hBEEF, 16);
    check_eq("mid_pairs",     n_vrise - v0, 1);
    check_eq("mid_left",      mon_l, 16'hCAFE);
    check_eq("mid_right",     mon_r, 16'hBEEF);
    check_eq("mid_lock",      mon_lock, 1);
    check_eq("mid_lock_prev", mon_lock_prev, 0);

    // reset mid-left-slot; the interrupted frame must not produce a pair
    part = 16'h5A5A;
    for (int i = 15; i >= 10; i--) sck_bit(1'b0, part[i]);
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    check_eq("mrst_valid",  rx.o_valid, 0);
    check_eq("mrst_left",   rx.o_left, 0);
    check_eq("mrst_right",  rx.o_right, 0);
    check_eq("mrst_locked", rx.o_locked, 0);
    i_rst_n = 1'b1;
    v0 = n_vrise;
    for (int i = 9; i >= 0; i--) sck_bit(i == 0, part[i]);
    part = 16'hA5A5;
    for (int i = 15; i >= 0; i--) sck_bit(i != 0, part[i]);
    check_eq("mrst_no_partial", n_vrise - v0, 0);
    send_frame(32'h0F0F, 16, 32'hF0F0, 16);
    check_eq("mrst_pairs", n_vrise - v0, 1);
    check_eq("mrst_left2", mon_l, 16'h0F0F);
    check_eq("mrst_right2", mon_r, 16'hF0F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
